logic_unit_arbiter: RTL
=======================

Name: logic_unit_arbiter

Overview:
- Shares one WIDTH-bit bitwise logic unit (AND/OR/XOR/NOR) between two requesters.
- Each requester has a valid/ready request channel. Results return on a single response channel tagged with the requester ID.
- Round-robin arbitration and a 3-state sequencer; one operation is in flight at a time.
- Sits between the decode/issue logic and the shared logic datapath, next to xor_32b and the other 32-bit gate blocks.

Parameters:
- WIDTH, 32, operand/result width in bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 request accepted this cycle.
- req0_op  input  2  requester 0 opcode: 00 AND, 01 OR, 10 XOR, 11 NOR.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- rsp_valid  output  1  result available.
- rsp_id  output  1  requester that owns the result.
- rsp_z  output  WIDTH  result.
- rsp_ready  input  1  consumer accepts the result.

Behaviour:
- Reset (async, rst=1):
  - State=IDLE, priority pointer prio=0.
  - rsp_valid=0, rsp_id=0, rsp_z=0.
  - Operand/op registers cleared.
  - req0_ready=req1_ready=0 while rst is high.
- States:
  - IDLE: accepting requests.
  - EXEC: operands latched; logic unit evaluates.
  - RESP: result held on the response port.
- IDLE, arbitration (combinational):
  - Only one valid: that requester is the winner.
  - Both valid: winner = prio.
  - reqN_ready=1 only for the winner and only in IDLE; otherwise 0.
  - Handshake when winner's valid and ready are both 1. On that edge: latch op, a, b and winner ID; prio <= ~winner; go to EXEC.
  - No valid requests: stay in IDLE; prio unchanged.
- EXEC:
  - Result of the latched op is registered into rsp_z; rsp_id <= latched ID; rsp_valid <= 1; go to RESP.
  - Exactly one cycle.
- RESP:
  - rsp_valid=1; rsp_z and rsp_id stable.
  - rsp_ready=1: rsp_valid <= 0; go to IDLE. rsp_z keeps its last value.
  - rsp_ready=0: hold indefinitely.
  - Both req_ready are 0 throughout RESP.
- Latency: handshake at edge N; rsp_valid high after edge N+1, i.e. visible during cycle N+2. Minimum issue interval is 3 cycles per operation (IDLE, EXEC, RESP).
- Arithmetic:
  - Purely bitwise; no carry, no overflow.
  - NOR = ~(a|b) over the full WIDTH bits.
- Stability: requesters must hold op/a/b stable while valid && !ready. The block samples them only on the handshake edge.
- Starvation: a requester that stays valid is granted within 2 grants.
- Reset mid-operation: any in-flight result is discarded, rsp_valid drops immediately (async), and prio returns to 0.
- Simultaneous rsp_ready with new valid requests: no request is accepted in the same cycle as the response handshake. Arbitration resumes in the following IDLE cycle.

Decomposition:
- Shared package:
  - opcode constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOR=2'b11.
  - state encodings S_IDLE, S_EXEC, S_RESP.
- Sub-module logic_op_32b (a, b, op -> z, purely combinational).
  - Wraps the existing bitwise gate blocks, including xor_32b, behind an op mux.
  - Instantiated once, fed from the latched operand registers.

Test Plan:
- Reset, then req0 XOR a=32'hffffffff b=32'h11111111 -> req0_ready=1 in cycle 0; rsp_valid=1, rsp_id=0, rsp_z=32'heeeeeeee two cycles after the handshake.
- Both valid and held; req0 AND a=32'hffff0000 b=32'h0f0f0f0f; req1 OR a=32'h11111111 b=32'h00000000; rsp_ready=1 throughout:
  - 1st response: id=0, z=32'h0f0f0000.
  - 2nd response: id=1, z=32'h11111111.
  - Following grant goes back to req0 (alternation).
- req1 NOR a=32'h00000000 b=32'h00000000 with rsp_ready=0 for 5 cycles -> rsp_valid, id=1, z=32'hffffffff held stable; req0/req1_ready stay 0; completes on the cycle rsp_ready rises.
- rst asserted during EXEC -> rsp_valid stays 0; state IDLE; prio=0; the next simultaneous request pair grants req0 first.
- rsp_ready=1 in the same cycle req1_valid=1 -> req1 is not accepted that cycle; it is accepted the next cycle (req1_ready=1 in IDLE).
- Back-to-back req0 XOR a=b=32'h11111111 -> z=32'h00000000; handshakes spaced exactly 3 cycles apart when rsp_ready is held at 1.

Source files
------------

// File: rtl/logic_unit_arbiter_pkg.sv
// logic_unit_arbiter_pkg: opcodes and sequencer states shared by the arbiter and its logic unit
package logic_unit_arbiter_pkg;
    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;
endpackage

// File: rtl/logic_unit_arbiter_op.sv
// logic_op_32b: combinational bitwise unit; a, b, op in -> z out (AND/OR/XOR/NOR)
module logic_op_32b
    import logic_unit_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] z
);
    logic [WIDTH-1:0] w_and, w_or, w_xor;
    assign w_and = a & b;
    assign w_or  = a | b;
    assign w_xor = a ^ b;
    assign z = op == OP_AND ? w_and :
               op == OP_OR  ? w_or  :
               op == OP_XOR ? w_xor : ~w_or;
endmodule

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin sharing of one bitwise logic unit between two requesters
// ports: clk/rst (async active-high); req0_*/req1_* valid/ready request channels with op, a, b;
//        rsp_valid/rsp_ready response channel carrying rsp_id and rsp_z
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_z,
    input  logic             rsp_ready
);
    state_t           r_state, w_next;
    logic             r_prio, r_id, w_win, w_hs;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a, r_b, w_z;
    // a lone valid requester wins outright; prio only breaks ties
    assign w_win = (req0_valid && req1_valid) ? r_prio : req1_valid;
    // ready is masked during reset because the async reset forces IDLE immediately
    assign req0_ready = !rst && r_state == S_IDLE && req0_valid && !w_win;
    assign req1_ready = !rst && r_state == S_IDLE && req1_valid && w_win;
    assign w_hs = req0_ready || req1_ready;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        w_next = r_state == S_IDLE ? (w_hs ? S_EXEC : S_IDLE) :
                 r_state == S_EXEC ? S_RESP :
                 (rsp_ready ? S_IDLE : S_RESP);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio    <= 1'b0;
            r_id      <= 1'b0;
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_z     <= '0;
        end else begin
            if (w_hs) begin
                r_op   <= w_win ? req1_op : req0_op;
                r_a    <= w_win ? req1_a : req0_a;
                r_b    <= w_win ? req1_b : req0_b;
                r_id   <= w_win;
                r_prio <= ~w_win;
            end
            if (r_state == S_EXEC) begin
                rsp_z     <= w_z;
                rsp_id    <= r_id;
                rsp_valid <= 1'b1;
            end
            if (r_state == S_RESP && rsp_ready) rsp_valid <= 1'b0;
        end
    end
    logic_op_32b #(.WIDTH(WIDTH)) u_op (
        .a (r_a),
        .b (r_b),
        .op(r_op),
        .z (w_z)
    );
endmodule
